// File: rtl/mem_ctrl_if.sv
// Request/response and RAM byte-bus bundle for the IF/MEM single-port arbiter.
// slave = the arbiter itself, master = the pipeline stages plus the RAM.
interface mem_ctrl_if #(parameter int ADDR_W = 17);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              stall_if_req;
    logic              stall_mem_req;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout,
               stall_if_req, stall_mem_req
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout,
               stall_if_req, stall_mem_req
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF fetches and MEM loads/stores onto an 8-bit single-port RAM.
// Optional MEM_CTRL_IO_WAIT_EN adds io_buffer_full back-pressure on writes to the top address quarter.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic clk,
    input  logic reset,
`ifdef MEM_CTRL_IO_WAIT_EN
    input  logic io_buffer_full,
`endif
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r;
    logic              owner_mem_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        n_r;
    logic [2:0]        cnt_r;
    logic [23:0]       wdata_hi_r;
    logic [31:0]       buf_r;
    logic [31:0]       if_data_r;
    logic              if_done_r;
    logic [31:0]       mem_rdata_r;
    logic              mem_done_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_we_r;
    logic [7:0]        ram_dout_r;

    logic [2:0]        cnt_inc_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [31:0]       buf_next_s;
    logic [7:0]        wbyte_next_s;
    logic              wait_s;
    logic              unused_addr_s;

    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign cnt_inc_s     = cnt_r + 3'd1;
    assign next_addr_s   = addr_r + ADDR_W'(cnt_inc_s);
    assign unused_addr_s = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

`ifdef MEM_CTRL_IO_WAIT_EN
    // A write byte into the top quarter stalls while the I/O buffer is full.
    assign wait_s = (state_r == BUSY) & we_r & (ram_addr_r[ADDR_W-1 -: 2] == 2'b11) & io_buffer_full;
`else
    assign wait_s = 1'b0;
`endif

    // Read data for cycle cnt belongs to the address driven one cycle earlier.
    always_comb begin
        buf_next_s = buf_r;
        case (cnt_r)
            3'd1:    buf_next_s[7:0]   = bus.ram_din;
            3'd2:    buf_next_s[15:8]  = bus.ram_din;
            3'd3:    buf_next_s[23:16] = bus.ram_din;
            3'd4:    buf_next_s[31:24] = bus.ram_din;
            default: buf_next_s        = buf_r;
        endcase
    end

    // Store byte to present on the next write cycle.
    always_comb begin
        wbyte_next_s = 8'h00;
        case (cnt_inc_s)
            3'd1:    wbyte_next_s = wdata_hi_r[7:0];
            3'd2:    wbyte_next_s = wdata_hi_r[15:8];
            3'd3:    wbyte_next_s = wdata_hi_r[23:16];
            default: wbyte_next_s = 8'h00;
        endcase
    end

    // Arbitration FSM with registered RAM and completion outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_mem_r <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            n_r         <= 3'd0;
            cnt_r       <= 3'd0;
            wdata_hi_r  <= 24'h000000;
            buf_r       <= 32'h00000000;
            if_data_r   <= 32'h00000000;
            if_done_r   <= 1'b0;
            mem_rdata_r <= 32'h00000000;
            mem_done_r  <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_we_r    <= 1'b0;
            ram_dout_r  <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    cnt_r      <= 3'd0;
                    buf_r      <= 32'h00000000;
                    if (bus.mem_req) begin
                        state_r     <= BUSY;
                        owner_mem_r <= 1'b1;
                        we_r        <= bus.mem_we;
                        addr_r      <= bus.mem_addr[ADDR_W-1:0];
                        n_r         <= byte_count(bus.mem_width);
                        wdata_hi_r  <= bus.mem_wdata[31:8];
                        ram_addr_r  <= bus.mem_addr[ADDR_W-1:0];
                        ram_we_r    <= bus.mem_we;
                        ram_dout_r  <= bus.mem_we ? bus.mem_wdata[7:0] : 8'h00;
                    end else if (bus.if_req) begin
                        state_r     <= BUSY;
                        owner_mem_r <= 1'b0;
                        we_r        <= 1'b0;
                        addr_r      <= bus.if_addr[ADDR_W-1:0];
                        n_r         <= 3'd4;
                        wdata_hi_r  <= 24'h000000;
                        ram_addr_r  <= bus.if_addr[ADDR_W-1:0];
                        ram_we_r    <= 1'b0;
                        ram_dout_r  <= 8'h00;
                    end else begin
                        ram_addr_r  <= {ADDR_W{1'b0}};
                        ram_we_r    <= 1'b0;
                        ram_dout_r  <= 8'h00;
                    end
                end
                BUSY: begin
                    if (!owner_mem_r && !bus.if_req) begin
                        // Branch flush: drop the fetch and its partial buffer.
                        state_r    <= IDLE;
                        cnt_r      <= 3'd0;
                        ram_addr_r <= {ADDR_W{1'b0}};
                        ram_we_r   <= 1'b0;
                        ram_dout_r <= 8'h00;
                    end else if (wait_s) begin
                        cnt_r <= cnt_r;
                    end else if (we_r) begin
                        if (cnt_inc_s < n_r) begin
                            cnt_r      <= cnt_inc_s;
                            ram_addr_r <= next_addr_s;
                            ram_we_r   <= 1'b1;
                            ram_dout_r <= wbyte_next_s;
                        end else begin
                            state_r     <= DONE;
                            cnt_r       <= 3'd0;
                            mem_done_r  <= 1'b1;
                            mem_rdata_r <= 32'h00000000;
                            ram_addr_r  <= {ADDR_W{1'b0}};
                            ram_we_r    <= 1'b0;
                            ram_dout_r  <= 8'h00;
                        end
                    end else begin
                        buf_r      <= buf_next_s;
                        ram_we_r   <= 1'b0;
                        ram_dout_r <= 8'h00;
                        if (cnt_inc_s < n_r) begin
                            ram_addr_r <= next_addr_s;
                        end else begin
                            ram_addr_r <= {ADDR_W{1'b0}};
                        end
                        if (cnt_r == n_r) begin
                            state_r <= DONE;
                            cnt_r   <= 3'd0;
                            if (owner_mem_r) begin
                                mem_done_r  <= 1'b1;
                                mem_rdata_r <= buf_next_s;
                            end else begin
                                if_done_r <= 1'b1;
                                if_data_r <= buf_next_s;
                            end
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    ram_addr_r <= {ADDR_W{1'b0}};
                    ram_we_r   <= 1'b0;
                    ram_dout_r <= 8'h00;
                end
                default: begin
                    state_r    <= IDLE;
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    ram_addr_r <= {ADDR_W{1'b0}};
                    ram_we_r   <= 1'b0;
                    ram_dout_r <= 8'h00;
                end
            endcase
        end
    end

    assign bus.if_data       = if_data_r;
    assign bus.if_done       = if_done_r;
    assign bus.mem_rdata     = mem_rdata_r;
    assign bus.mem_done      = mem_done_r;
    assign bus.ram_addr      = ram_addr_r;
    assign bus.ram_we        = ram_we_r & ~wait_s;
    assign bus.ram_dout      = ram_dout_r;
    assign bus.stall_if_req  = bus.if_req & ~if_done_r;
    assign bus.stall_mem_req = bus.mem_req & ~mem_done_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, scoreboard of expected completions,
// one task per scenario. Inputs change on the falling edge, outputs are sampled there too.
module tb_mem_ctrl;
    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus();

`ifdef MEM_CTRL_IO_WAIT_EN
    logic io_buffer_full = 1'b0;
    mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .io_buffer_full(io_buffer_full), .bus(bus.slave));
`else
    mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [24:0] wlog[$];
    logic        both_seen = 1'b0;
    logic [7:0]  ram_mem [0:(1<<ADDR_W)-1];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    // RAM: registered read (data one cycle after the address), byte write.
    always @(posedge clk) begin
        bus.ram_din <= ram_mem[bus.ram_addr];
        if (bus.ram_we === 1'b1) ram_mem[bus.ram_addr] = bus.ram_dout;
    end

    // Write log and overlapping-completion detector.
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) wlog.push_back({bus.ram_addr, bus.ram_dout});
        if (bus.if_done === 1'b1 && bus.mem_done === 1'b1) both_seen = 1'b1;
    end

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        bus.mem_width = 2'b00; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    endtask

    task automatic drive_mem(input logic we, input logic [1:0] width, input logic [31:0] addr, input logic [31:0] wdata);
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_width = width; bus.mem_addr = addr; bus.mem_wdata = wdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        vec_cnt++; if (bus.if_done !== 1'b0) begin err_cnt++; $display("FAIL reset_if_done: got %b want 0", bus.if_done); end
        vec_cnt++; if (bus.mem_done !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_done: got %b want 0", bus.mem_done); end
        vec_cnt++; if (bus.if_data !== 32'h0) begin err_cnt++; $display("FAIL reset_if_data: got %h want 0", bus.if_data); end
        vec_cnt++; if (bus.mem_rdata !== 32'h0) begin err_cnt++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
        vec_cnt++; if (bus.ram_we !== 1'b0) begin err_cnt++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
        vec_cnt++; if (bus.ram_addr !== 17'h0) begin err_cnt++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr); end
        vec_cnt++; if (bus.ram_dout !== 8'h0) begin err_cnt++; $display("FAIL reset_ram_dout: got %h want 0", bus.ram_dout); end
        // Requests held during reset must not start an access but still raise stalls.
        bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_req = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++; if (bus.stall_if_req !== 1'b1) begin err_cnt++; $display("FAIL reset_stall_if: got %b want 1", bus.stall_if_req); end
        vec_cnt++; if (bus.stall_mem_req !== 1'b1) begin err_cnt++; $display("FAIL reset_stall_mem: got %b want 1", bus.stall_mem_req); end
        vec_cnt++; if (bus.ram_addr !== 17'h0) begin err_cnt++; $display("FAIL reset_hold_addr: got %h want 0", bus.ram_addr); end
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch();
        ram_mem[17'h100] = 8'h11; ram_mem[17'h101] = 8'h22; ram_mem[17'h102] = 8'h33; ram_mem[17'h103] = 8'h44;
        sb_q.push_back('{is_mem: 1'b0, data: 32'h44332211});
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) begin
                vec_cnt++; if (bus.ram_addr !== 17'(32'h100 + c)) begin err_cnt++; $display("FAIL fetch_addr c%0d: got %h want %h", c, bus.ram_addr, 17'(32'h100 + c)); end
            end
            vec_cnt++; if (bus.ram_we !== 1'b0) begin err_cnt++; $display("FAIL fetch_we c%0d: got %b want 0", c, bus.ram_we); end
            vec_cnt++; if (bus.if_done !== (c == 5)) begin err_cnt++; $display("FAIL fetch_done c%0d: got %b want %b", c, bus.if_done, (c == 5)); end
            vec_cnt++; if (bus.stall_if_req !== (c < 5)) begin err_cnt++; $display("FAIL fetch_stall c%0d: got %b want %b", c, bus.stall_if_req, (c < 5)); end
            if (bus.if_done === 1'b1) begin
                e = sb_q.pop_front();
                vec_cnt++; if (bus.if_data !== e.data || e.is_mem !== 1'b0) begin err_cnt++; $display("FAIL fetch_data: got %h want %h", bus.if_data, e.data); end
                bus.if_req = 1'b0;
            end
        end
        vec_cnt++; if (sb_q.size() != 0) begin err_cnt++; $display("FAIL fetch_sb_left: got %0d want 0", sb_q.size()); sb_q.delete(); end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_store();
        ram_mem[17'h206] = 8'h5A;
        wlog.delete();
        drive_mem(1'b1, 2'b01, 32'h0000_0204, 32'hAABBCCDD);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vec_cnt++; if (bus.mem_done !== (c == 2)) begin err_cnt++; $display("FAIL store_done c%0d: got %b want %b", c, bus.mem_done, (c == 2)); end
            vec_cnt++; if (bus.if_done !== 1'b0) begin err_cnt++; $display("FAIL store_if_done c%0d: got %b want 0", c, bus.if_done); end
            vec_cnt++; if (bus.stall_mem_req !== (c < 2)) begin err_cnt++; $display("FAIL store_stall c%0d: got %b want %b", c, bus.stall_mem_req, (c < 2)); end
            if (c == 2) idle_inputs();
        end
        vec_cnt++; if (wlog.size() != 2) begin err_cnt++; $display("FAIL store_wcount: got %0d want 2", wlog.size()); end
        if (wlog.size() == 2) begin
            vec_cnt++; if (wlog[0] !== {17'h204, 8'hDD}) begin err_cnt++; $display("FAIL store_w0: got %h want %h", wlog[0], {17'h204, 8'hDD}); end
            vec_cnt++; if (wlog[1] !== {17'h205, 8'hCC}) begin err_cnt++; $display("FAIL store_w1: got %h want %h", wlog[1], {17'h205, 8'hCC}); end
        end
        vec_cnt++; if (ram_mem[17'h206] !== 8'h5A) begin err_cnt++; $display("FAIL store_206: got %h want 5a", ram_mem[17'h206]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        ram_mem[17'h10] = 8'h80;
        ram_mem[17'h300] = 8'h05; ram_mem[17'h301] = 8'h06; ram_mem[17'h302] = 8'h07; ram_mem[17'h303] = 8'h08;
        both_seen = 1'b0;
        sb_q.push_back('{is_mem: 1'b1, data: 32'h00000080});
        sb_q.push_back('{is_mem: 1'b0, data: 32'h08070605});
        drive_mem(1'b0, 2'b00, 32'h0000_0010, 32'h0);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            vec_cnt++; if (bus.mem_done !== (c == 2)) begin err_cnt++; $display("FAIL prio_mem_done c%0d: got %b want %b", c, bus.mem_done, (c == 2)); end
            vec_cnt++; if (bus.if_done !== (c == 9)) begin err_cnt++; $display("FAIL prio_if_done c%0d: got %b want %b", c, bus.if_done, (c == 9)); end
            if ((bus.mem_done === 1'b1 || bus.if_done === 1'b1) && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vec_cnt++; if (bus.mem_done !== e.is_mem) begin err_cnt++; $display("FAIL prio_order c%0d: got mem=%b want mem=%b", c, bus.mem_done, e.is_mem); end
                vec_cnt++; if ((e.is_mem ? bus.mem_rdata : bus.if_data) !== e.data) begin err_cnt++; $display("FAIL prio_data c%0d: got %h want %h", c, (e.is_mem ? bus.mem_rdata : bus.if_data), e.data); end
            end
            if (bus.mem_done === 1'b1) bus.mem_req = 1'b0;
            if (bus.if_done === 1'b1) bus.if_req = 1'b0;
        end
        vec_cnt++; if (both_seen !== 1'b0) begin err_cnt++; $display("FAIL prio_both_done: got %b want 0", both_seen); end
        vec_cnt++; if (sb_q.size() != 0) begin err_cnt++; $display("FAIL prio_sb_left: got %0d want 0", sb_q.size()); sb_q.delete(); end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vec_cnt++; if (bus.if_done !== 1'b0) begin err_cnt++; $display("FAIL abort_if_done c%0d: got %b want 0", c, bus.if_done); end
            vec_cnt++; if (bus.mem_done !== (c == 9)) begin err_cnt++; $display("FAIL abort_mem_done c%0d: got %b want %b", c, bus.mem_done, (c == 9)); end
            if (c == 3) begin
                vec_cnt++; if (bus.ram_addr !== 17'h0) begin err_cnt++; $display("FAIL abort_idle_addr: got %h want 0", bus.ram_addr); end
                sb_q.push_back('{is_mem: 1'b1, data: 32'h44332211});
                drive_mem(1'b0, 2'b10, 32'h0000_0100, 32'h0);
            end
            if (c == 4) begin
                vec_cnt++; if (bus.ram_addr !== 17'h100) begin err_cnt++; $display("FAIL abort_new_addr: got %h want 100", bus.ram_addr); end
            end
            if (bus.mem_done === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vec_cnt++; if (bus.mem_rdata !== e.data) begin err_cnt++; $display("FAIL abort_load_data: got %h want %h", bus.mem_rdata, e.data); end
                bus.mem_req = 1'b0;
            end
            if (c == 2) bus.if_req = 1'b0;
        end
        vec_cnt++; if (sb_q.size() != 0) begin err_cnt++; $display("FAIL abort_sb_left: got %0d want 0", sb_q.size()); sb_q.delete(); end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) ram_mem[17'(32'h400 + i)] = 8'hEE;
        wlog.delete();
        drive_mem(1'b1, 2'b10, 32'h0000_0400, 32'h01020304);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vec_cnt++; if ({bus.ram_we, bus.ram_addr, bus.ram_dout} !== {1'b1, 17'h400, 8'h04}) begin err_cnt++; $display("FAIL rmid_c0: got %b/%h/%h want 1/400/04", bus.ram_we, bus.ram_addr, bus.ram_dout); end
            end else if (c == 1) begin
                vec_cnt++; if ({bus.ram_we, bus.ram_addr, bus.ram_dout} !== {1'b1, 17'h401, 8'h03}) begin err_cnt++; $display("FAIL rmid_c1: got %b/%h/%h want 1/401/03", bus.ram_we, bus.ram_addr, bus.ram_dout); end
                reset = 1'b1;
                idle_inputs();
            end else begin
                vec_cnt++; if ({bus.ram_we, bus.ram_addr, bus.ram_dout} !== {1'b0, 17'h0, 8'h00}) begin err_cnt++; $display("FAIL rmid_ram c%0d: got %b/%h/%h want 0/0/0", c, bus.ram_we, bus.ram_addr, bus.ram_dout); end
                vec_cnt++; if ({bus.mem_done, bus.if_done, bus.mem_rdata} !== 34'h0) begin err_cnt++; $display("FAIL rmid_done c%0d: got %b/%b/%h want 0/0/0", c, bus.mem_done, bus.if_done, bus.mem_rdata); end
                if (c == 3) reset = 1'b0;
            end
        end
        vec_cnt++; if ({ram_mem[17'h400], ram_mem[17'h401], ram_mem[17'h402], ram_mem[17'h403]} !== 32'h0403EEEE) begin
            err_cnt++; $display("FAIL rmid_ram_content: got %h%h%h%h want 0403eeee", ram_mem[17'h400], ram_mem[17'h401], ram_mem[17'h402], ram_mem[17'h403]);
        end
        vec_cnt++; if (wlog.size() != 2) begin err_cnt++; $display("FAIL rmid_wcount: got %0d want 2", wlog.size()); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [16:0] want_addr [4];
        want_addr[0] = 17'h1FFFF; want_addr[1] = 17'h00000; want_addr[2] = 17'h00001; want_addr[3] = 17'h00002;
        ram_mem[17'h1FFFF] = 8'hA1; ram_mem[17'h0] = 8'hB2; ram_mem[17'h1] = 8'hC3; ram_mem[17'h2] = 8'hD4;
        sb_q.push_back('{is_mem: 1'b1, data: 32'hD4C3B2A1});
        drive_mem(1'b0, 2'b10, 32'h0001_FFFF, 32'h0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 4) begin
                vec_cnt++; if (bus.ram_addr !== want_addr[c]) begin err_cnt++; $display("FAIL wrap_addr c%0d: got %h want %h", c, bus.ram_addr, want_addr[c]); end
            end
            vec_cnt++; if (bus.mem_done !== (c == 5)) begin err_cnt++; $display("FAIL wrap_done c%0d: got %b want %b", c, bus.mem_done, (c == 5)); end
            if (bus.mem_done === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vec_cnt++; if (bus.mem_rdata !== e.data) begin err_cnt++; $display("FAIL wrap_data: got %h want %h", bus.mem_rdata, e.data); end
                bus.mem_req = 1'b0;
            end
        end
        vec_cnt++; if (sb_q.size() != 0) begin err_cnt++; $display("FAIL wrap_sb_left: got %0d want 0", sb_q.size()); sb_q.delete(); end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    // Back-to-back loads of random width/address; width 11 must behave as a word.
    task automatic test_back_to_back();
        for (int t = 0; t < 8; t++) begin
            logic [1:0]  w;
            logic [16:0] a;
            logic [7:0]  b [4];
            logic [31:0] want;
            int          n;
            int          seen_c;
            @(negedge clk);
            w = 2'($urandom_range(0, 3));
            a = 17'($urandom);
            for (int i = 0; i < 4; i++) begin
                b[i] = 8'($urandom);
                ram_mem[17'(a + 17'(i))] = b[i];
            end
            n = (w == 2'b00) ? 1 : ((w == 2'b01) ? 2 : 4);
            want = {(n == 4) ? b[3] : 8'h00, (n == 4) ? b[2] : 8'h00, (n >= 2) ? b[1] : 8'h00, b[0]};
            sb_q.push_back('{is_mem: 1'b1, data: want});
            drive_mem(1'b0, w, {15'($urandom), a}, 32'($urandom));
            seen_c = -1;
            for (int c = 0; c < 8 && seen_c < 0; c++) begin
                @(negedge clk);
                if (bus.mem_done === 1'b1) begin
                    seen_c = c;
                    e = sb_q.pop_front();
                    vec_cnt++; if (bus.mem_rdata !== e.data) begin err_cnt++; $display("FAIL b2b_data t%0d w%0d a%h: got %h want %h", t, w, a, bus.mem_rdata, e.data); end
                    bus.mem_req = 1'b0;
                end
            end
            vec_cnt++; if (seen_c != n + 1) begin err_cnt++; $display("FAIL b2b_latency t%0d: got cycle %0d want %0d", t, seen_c, n + 1); end
            if (seen_c < 0) begin
                sb_q.delete();
                idle_inputs();
                repeat (8) @(negedge clk);
            end
        end
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = 8'h00;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
